// File: rtl/rggen_register_access_initiator_if.sv
// rggen_register_access_initiator_if: host command/response and register-bus signals; master = initiator side, slave = host/register-block side
interface rggen_register_access_initiator_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                      command_valid;
  logic                      command_ready;
  logic                      command_write;
  logic [ADDRESS_WIDTH-1:0]  command_address;
  logic [DATA_WIDTH-1:0]     command_write_data;
  logic [DATA_WIDTH/8-1:0]   command_strobe;
  logic                      response_valid;
  logic                      response_ready;
  logic [1:0]                response_status;
  logic [DATA_WIDTH-1:0]     response_read_data;
  logic                      register_valid;
  logic                      register_write;
  logic [ADDRESS_WIDTH-1:0]  register_address;
  logic [DATA_WIDTH-1:0]     register_write_data;
  logic [DATA_WIDTH/8-1:0]   register_strobe;
  logic                      register_ready;
  logic [1:0]                register_status;
  logic [DATA_WIDTH-1:0]     register_read_data;
  modport master (
    input  command_valid, command_write, command_address, command_write_data, command_strobe,
    output command_ready,
    output response_valid, response_status, response_read_data,
    input  response_ready,
    output register_valid, register_write, register_address, register_write_data, register_strobe,
    input  register_ready, register_status, register_read_data
  );
  modport slave (
    output command_valid, command_write, command_address, command_write_data, command_strobe,
    input  command_ready,
    input  response_valid, response_status, response_read_data,
    output response_ready,
    input  register_valid, register_write, register_address, register_write_data, register_strobe,
    output register_ready, register_status, register_read_data
  );
endinterface

// File: rtl/rggen_register_access_initiator.sv
// rggen_register_access_initiator: one-at-a-time host command -> word-aligned register request with timeout; ports i_clk, i_rst (sync, active-high), bus (command/response/register signals)
module rggen_register_access_initiator #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic i_clk,
  input logic i_rst,
  rggen_register_access_initiator_if.master bus
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int CW  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQUEST, RESPOND} state_t;
  state_t                    state, state_n;
  logic                      write_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [SW-1:0]             strobe_q;
  logic [1:0]                status_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [CW-1:0]             cnt_q;
  logic                      accept, done, expire;
  always_comb begin
    accept  = state == IDLE && bus.command_valid;
    done    = state == REQUEST && bus.register_ready;
    expire  = TIMEOUT_CYCLES != 0 && state == REQUEST && !bus.register_ready && cnt_q + CW'(1) == CNT_MAX;
    state_n = accept ? REQUEST
            : (done || expire) ? RESPOND
            : (state == RESPOND && bus.response_ready) ? IDLE
            : state;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      status_q <= 2'b00;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        write_q  <= bus.command_write;
        addr_q   <= bus.command_address & ADDR_MASK;
        wdata_q  <= bus.command_write ? bus.command_write_data : '0;
        strobe_q <= bus.command_write ? bus.command_strobe : '0;
        cnt_q    <= '0;
      end
      if (state == REQUEST && !bus.register_ready)
        cnt_q <= cnt_q + CW'(1);
      if (done) begin
        status_q <= (bus.register_status != 2'b00) ? 2'b10 : 2'b00;
        rdata_q  <= (!write_q && bus.register_status == 2'b00) ? bus.register_read_data : '0;
      end else if (expire) begin
        status_q <= 2'b11;
        rdata_q  <= '0;
      end
    end
  assign bus.command_ready       = state == IDLE;
  assign bus.register_valid      = state == REQUEST;
  assign bus.response_valid      = state == RESPOND;
  assign bus.register_write      = write_q;
  assign bus.register_address    = addr_q;
  assign bus.register_write_data = wdata_q;
  assign bus.register_strobe     = strobe_q;
  assign bus.response_status     = status_q;
  assign bus.response_read_data  = rdata_q;
endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// tb_rggen_register_access_initiator: randomized self-checking bench against a per-transaction reference model
module tb_rggen_register_access_initiator;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  rggen_register_access_initiator_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  rggen_register_access_initiator #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, DW'(bus.command_ready), 1);
    check({tag, "_resp_valid"}, DW'(bus.response_valid), 0);
    check({tag, "_reg_valid"}, DW'(bus.register_valid), 0);
    check({tag, "_reg_write"}, DW'(bus.register_write), 0);
    check({tag, "_reg_addr"}, DW'(bus.register_address), 0);
    check({tag, "_reg_wdata"}, bus.register_write_data, 0);
    check({tag, "_reg_strobe"}, DW'(bus.register_strobe), 0);
    check({tag, "_resp_status"}, DW'(bus.response_status), 0);
    check({tag, "_resp_rdata"}, bus.response_read_data, 0);
  endtask
  // delay = REQUEST cycles without ready before ready is given; delay >= TO means it never comes
  task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [SW-1:0] st, input int delay, input logic [1:0] rs,
                     input logic [DW-1:0] rd, input int wait_n);
    bit             to_exp = TO != 0 && delay >= TO;
    int             cycles = to_exp ? TO : delay + 1;
    logic [AW-1:0]  ea     = AW'((int'(addr) / SW) * SW);
    logic [1:0]     es     = to_exp ? 2'b11 : (rs != 2'b00 ? 2'b10 : 2'b00);
    logic [DW-1:0]  ed     = (es == 2'b00 && !wr) ? rd : '0;
    check("accept_ready", DW'(bus.command_ready), 1);
    bus.command_valid      = 1'b1;
    bus.command_write      = wr;
    bus.command_address    = addr;
    bus.command_write_data = wd;
    bus.command_strobe     = st;
    step();
    bus.command_valid      = 1'($urandom_range(0, 1));
    bus.command_write      = 1'($urandom_range(0, 1));
    bus.command_address    = AW'($urandom);
    bus.command_write_data = $urandom;
    bus.command_strobe     = SW'($urandom);
    for (int i = 0; i < cycles; i++) begin
      check("req_valid", DW'(bus.register_valid), 1);
      check("req_addr", DW'(bus.register_address), DW'(ea));
      check("req_write", DW'(bus.register_write), DW'(wr));
      check("req_wdata", bus.register_write_data, wr ? wd : '0);
      check("req_strobe", DW'(bus.register_strobe), wr ? DW'(st) : '0);
      check("req_cmd_ready", DW'(bus.command_ready), 0);
      check("req_resp_valid", DW'(bus.response_valid), 0);
      bus.register_ready     = !to_exp && i == delay;
      bus.register_status    = bus.register_ready ? rs : 2'($urandom);
      bus.register_read_data = bus.register_ready ? rd : $urandom;
      step();
    end
    bus.register_ready = 1'b0;
    bus.command_valid  = 1'b1;
    for (int i = 0; i <= wait_n; i++) begin
      check("rsp_reg_valid", DW'(bus.register_valid), 0);
      check("rsp_valid", DW'(bus.response_valid), 1);
      check("rsp_status", DW'(bus.response_status), DW'(es));
      check("rsp_rdata", bus.response_read_data, ed);
      check("rsp_cmd_ready", DW'(bus.command_ready), 0);
      bus.response_ready     = i == wait_n;
      bus.register_ready     = 1'($urandom_range(0, 1));
      bus.register_status    = 2'($urandom);
      bus.register_read_data = $urandom;
      step();
    end
    bus.response_ready = 1'b0;
    bus.register_ready = 1'b0;
    bus.command_valid  = 1'b0;
    check("post_cmd_ready", DW'(bus.command_ready), 1);
    check("post_resp_valid", DW'(bus.response_valid), 0);
    check("post_reg_valid", DW'(bus.register_valid), 0);
  endtask
  initial begin
    bus.command_valid      = 1'b0;
    bus.command_write      = 1'b0;
    bus.command_address    = '0;
    bus.command_write_data = '0;
    bus.command_strobe     = '0;
    bus.response_ready     = 1'b0;
    bus.register_ready     = 1'b0;
    bus.register_status    = 2'b00;
    bus.register_read_data = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check_reset_outputs("reset");
    txn(1'b0, 8'h13, 32'hFFFF_FFFF, 4'hF, 0, 2'b00, 32'hCAFEF00D, 0);
    txn(1'b1, 8'h08, 32'h12345678, 4'b0011, 5, 2'b00, 32'hDEADBEEF, 0);
    txn(1'b0, 8'h22, 32'h0, 4'h0, TO + 3, 2'b00, 32'h11111111, 0);
    txn(1'b0, 8'h24, 32'h0, 4'h0, TO - 1, 2'b01, 32'h55AA55AA, 0);
    txn(1'b1, 8'h31, 32'hA5A5A5A5, 4'b1100, 2, 2'b00, 32'h0, 10);
    txn(1'b0, 8'h40, 32'h0, 4'h0, TO - 2, 2'b00, 32'h0BADCAFE, 1);
    bus.command_valid      = 1'b1;
    bus.command_write      = 1'b1;
    bus.command_address    = 8'h5C;
    bus.command_write_data = 32'h87654321;
    bus.command_strobe     = 4'hF;
    step();
    bus.command_valid = 1'b0;
    step();
    check("mid_reg_valid", DW'(bus.register_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    for (int i = 0; i < 4; i++) begin
      bus.register_ready = 1'b1;
      step();
      check("midrst_no_resp", DW'(bus.response_valid), 0);
      check("midrst_no_req", DW'(bus.register_valid), 0);
    end
    bus.register_ready = 1'b0;
    txn(1'b0, 8'h5F, 32'h0, 4'h0, 1, 2'b00, 32'h600DF00D, 0);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] rs;
      rs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom),
          int'($urandom_range(0, TO + 2)), rs, $urandom, int'($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
